// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S receive stream block.
package i2s_pkg;

  localparam int DEFAULT_DATA_WIDTH = 24;
  localparam int DEFAULT_MAX_SLOT   = 32;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, with registered rise/fall strobes.
module i2s_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign level = sync_reg;
  assign rise  = sync_reg & ~prev_reg;
  assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/i2s_rx_stream.sv
// I2S / left-justified serial receiver delivering MSB-aligned stereo pairs
// through a valid/ready output with overrun and short-word reporting.
module i2s_rx_stream
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_SLOT   = DEFAULT_MAX_SLOT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  input  logic                  lj_mode,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_left,
  output logic [DATA_WIDTH-1:0] data_right,
  output logic                  overrun,
  output logic                  short_word
);

  localparam int CNT_W   = $clog2(MAX_SLOT + 1);
  localparam int IDX_SCK = 0;
  localparam int IDX_WS  = 1;
  localparam int IDX_SD  = 2;

  // Assertion is immediate; release is retimed to the next clk edge.
  logic rst_sync_n_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_n_reg <= 1'b0;
    else        rst_sync_n_reg <= 1'b1;
  end

  logic [2:0] async_in;
  logic [2:0] sync_lvl;
  logic [2:0] sync_rise;
  logic [2:0] sync_fall;
  assign async_in = {sd, ws, sck};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    i2s_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_sync_n_reg),
      .din   (async_in[gi]),
      .level (sync_lvl[gi]),
      .rise  (sync_rise[gi]),
      .fall  (sync_fall[gi])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{sync_lvl[IDX_SCK], sync_rise[IDX_SD:IDX_WS], sync_fall};

  logic sck_rise, ws_s, sd_s;
  assign sck_rise = sync_rise[IDX_SCK];
  assign ws_s     = sync_lvl[IDX_WS];
  assign sd_s     = sync_lvl[IDX_SD];

  state_t                state_reg, state_next;
  logic                  mode_reg;
  logic                  ws_prev_reg;
  logic                  chan_prev_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] left_hold_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;

  logic                  bit_chan, boundary, word_short;
  logic                  close_left, close_right;
  logic [31:0]           cnt_ext;
  logic [DATA_WIDTH-1:0] word_aligned;

  // Philips I2S delays data one bit behind ws; left-justified does not.
  assign bit_chan    = (mode_reg == MODE_LJ) ? ws_s : ws_prev_reg;
  assign boundary    = sck_rise && (bit_chan != chan_prev_reg);
  assign cnt_ext     = 32'(bit_cnt_reg);
  assign word_short  = cnt_ext < DATA_WIDTH;
  assign word_aligned = word_short ? (shift_reg << (DATA_WIDTH - cnt_ext)) : shift_reg;
  assign close_left  = boundary && (state_reg == ST_LEFT);
  assign close_right = boundary && (state_reg == ST_RIGHT);

  always_ff @(posedge clk or negedge rst_sync_n_reg) begin
    if (!rst_sync_n_reg) state_reg <= ST_SYNC;
    else                 state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (boundary) begin
      case (state_reg)
        ST_SYNC:  if (!bit_chan) state_next = ST_LEFT;
        ST_LEFT:  state_next = ST_RIGHT;
        ST_RIGHT: state_next = ST_LEFT;
        default:  state_next = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n_reg) begin
    if (!rst_sync_n_reg) begin
      mode_reg      <= MODE_I2S;
      ws_prev_reg   <= 1'b0;
      chan_prev_reg <= 1'b0;
      shift_reg     <= '0;
      left_hold_reg <= '0;
      bit_cnt_reg   <= '0;
      out_valid     <= 1'b0;
      data_left     <= '0;
      data_right    <= '0;
      overrun       <= 1'b0;
      short_word    <= 1'b0;
    end else begin
      overrun    <= 1'b0;
      short_word <= 1'b0;

      // Mode only changes while hunting for sync or at a word boundary.
      if (state_reg == ST_SYNC || boundary) mode_reg <= lj_mode;

      if (sck_rise) begin
        ws_prev_reg   <= ws_s;
        chan_prev_reg <= bit_chan;
        if (boundary && state_next != ST_SYNC) begin
          shift_reg   <= {{(DATA_WIDTH-1){1'b0}}, sd_s};
          bit_cnt_reg <= CNT_W'(1);
        end else if (state_reg != ST_SYNC) begin
          if (word_short)          shift_reg   <= {shift_reg[DATA_WIDTH-2:0], sd_s};
          if (cnt_ext < MAX_SLOT)  bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        end
      end

      if ((close_left || close_right) && word_short) short_word <= 1'b1;
      if (close_left) left_hold_reg <= word_aligned;

      if (close_right) begin
        if (!out_valid || out_ready) begin
          data_left  <= left_hold_reg;
          data_right <= word_aligned;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_stream.sv
// Directed and randomised bench for i2s_rx_stream: table vectors plus overrun,
// mid-word reset and a 100-frame scoreboard run, with SCK at clk/8.
module tb_i2s_rx_stream;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sck = 1'b0;
  logic          ws = 1'b0;
  logic          sd = 1'b0;
  logic          lj_mode = 1'b0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [DW-1:0] data_left;
  logic [DW-1:0] data_right;
  logic          overrun;
  logic          short_word;

  always #5 clk = ~clk;

  i2s_rx_stream #(.DATA_WIDTH(DW), .MAX_SLOT(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .lj_mode    (lj_mode),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .data_left  (data_left),
    .data_right (data_right),
    .overrun    (overrun),
    .short_word (short_word)
  );

  int checks = 0;
  int errors = 0;

  logic [2*DW-1:0] got_q[$];
  int ovr_cnt = 0;
  int short_cnt = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({data_left, data_right});
    if (overrun) ovr_cnt++;
    if (short_word) short_cnt++;
  end

  typedef struct {
    logic          mode;
    logic          fmt_lj;
    int            slot;
    int            wbits;
    logic [31:0]   l;
    logic [31:0]   r;
    logic [DW-1:0] exp_l;
    logic [DW-1:0] exp_r;
    int            exp_short;
  } vec_t;

  vec_t vecs[8];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [31:0] l, input logic [31:0] r,
                                     input int slot, input int wbits, input int p);
    logic [31:0] w;
    int k;
    w = (p >= slot) ? r : l;
    k = p % slot;
    return (k < wbits) ? w[wbits-1-k] : 1'b0;
  endfunction

  // One bit per iteration: data and ws change on the SCK falling edge.
  task automatic send_bits(input logic [31:0] l, input logic [31:0] r, input int slot,
                           input int wbits, input logic fmt_lj, input int p_from, input int p_to);
    for (int p = p_from; p < p_to; p++) begin
      sck = 1'b0;
      ws  = fmt_lj ? (p >= slot) : (((p + 1) % (2 * slot)) >= slot);
      sd  = frame_bit(l, r, slot, wbits, p);
      tick(4);
      sck = 1'b1;
      tick(4);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int slot,
                            input int wbits, input logic fmt_lj);
    send_bits(l, r, slot, wbits, fmt_lj, 0, 2 * slot);
  endtask

  task automatic do_reset();
    sck = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
  endtask

  initial begin
    int q0, o0, s0;
    logic [31:0] rl, rr;
    logic [2*DW-1:0] exp_q[$];

    vecs[0] = '{1'b0, 1'b0, 32, 24, 32'hA5A5A5,   32'h3C3C3C,   24'hA5A5A5, 24'h3C3C3C, 0};
    vecs[1] = '{1'b1, 1'b1, 32, 24, 32'hA5A5A5,   32'h3C3C3C,   24'hA5A5A5, 24'h3C3C3C, 0};
    vecs[2] = '{1'b0, 1'b1, 32, 24, 32'hA5A5A5,   32'h3C3C3C,   24'h4B4B4A, 24'h787878, 0};
    vecs[3] = '{1'b0, 1'b0, 16, 16, 32'hBEEF,     32'h1234,     24'hBEEF00, 24'h123400, 3};
    vecs[4] = '{1'b1, 1'b1, 16, 16, 32'hCAFE,     32'hF00D,     24'hCAFE00, 24'hF00D00, 3};
    vecs[5] = '{1'b0, 1'b0, 24, 24, 32'hFFFFFF,   32'h000001,   24'hFFFFFF, 24'h000001, 0};
    vecs[6] = '{1'b0, 1'b0, 32, 32, 32'h12345678, 32'h9ABCDEF0, 24'h123456, 24'h9ABCDE, 0};
    vecs[7] = '{1'b1, 1'b1, 8,  8,  32'h81,       32'h7E,       24'h810000, 24'h7E0000, 3};

    // Reset state
    tick(3);
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset data_left", 64'(data_left), 64'd0);
    check("reset data_right", 64'(data_right), 64'd0);
    check("reset overrun", 64'(overrun), 64'd0);
    check("reset short_word", 64'(short_word), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(4);

    // Table vectors: frame 1 is the sync frame, frame 2 is delivered, frame 3 stays open.
    for (int i = 0; i < 8; i++) begin
      lj_mode = vecs[i].mode;
      out_ready = 1'b1;
      do_reset();
      q0 = got_q.size();
      o0 = ovr_cnt;
      s0 = short_cnt;
      repeat (3) send_frame(vecs[i].l, vecs[i].r, vecs[i].slot, vecs[i].wbits, vecs[i].fmt_lj);
      tick(8);
      check($sformatf("vec%0d pair count", i), 64'(got_q.size() - q0), 64'd1);
      if (got_q.size() > q0)
        check($sformatf("vec%0d pair data", i), 64'(got_q[q0]), {16'd0, vecs[i].exp_l, vecs[i].exp_r});
      check($sformatf("vec%0d short_word pulses", i), 64'(short_cnt - s0), 64'(vecs[i].exp_short));
      check($sformatf("vec%0d overrun pulses", i), 64'(ovr_cnt - o0), 64'd0);
      $display("vec %0d: lj=%0d fmt_lj=%0d slot=%0d L=%h R=%h expect %h/%h",
               i, vecs[i].mode, vecs[i].fmt_lj, vecs[i].slot, vecs[i].l, vecs[i].r,
               vecs[i].exp_l, vecs[i].exp_r);
    end

    // Backpressure: first pair held, second pair dropped with one overrun pulse.
    lj_mode = 1'b0;
    do_reset();
    out_ready = 1'b0;
    q0 = got_q.size();
    o0 = ovr_cnt;
    send_frame(32'h000011, 32'h000022, 32, 24, 1'b0);
    send_frame(32'hAAAAAA, 32'h555555, 32, 24, 1'b0);
    send_frame(32'h111111, 32'h222222, 32, 24, 1'b0);
    send_frame(32'h333333, 32'h444444, 32, 24, 1'b0);
    tick(8);
    @(negedge clk);
    check("stall out_valid", 64'(out_valid), 64'd1);
    check("stall data_left", 64'(data_left), 64'hAAAAAA);
    check("stall data_right", 64'(data_right), 64'h555555);
    check("stall overrun pulses", 64'(ovr_cnt - o0), 64'd1);
    tick(1);
    out_ready = 1'b1;
    tick(4);
    @(negedge clk);
    check("release out_valid", 64'(out_valid), 64'd0);
    check("release pair count", 64'(got_q.size() - q0), 64'd1);
    if (got_q.size() > q0) check("release pair data", 64'(got_q[q0]), 64'hAAAAAA_555555);
    $display("overrun seq: held AAAAAA/555555, dropped 111111/222222");

    // Reset in the middle of a left word.
    do_reset();
    q0 = got_q.size();
    send_frame(32'h0F0F0F, 32'hF0F0F0, 32, 24, 1'b0);
    send_frame(32'h123456, 32'h654321, 32, 24, 1'b0);
    send_bits(32'hDEADBE, 32'hEFCAFE, 32, 24, 1'b0, 0, 11);
    check("pre-reset pair count", 64'(got_q.size() - q0), 64'd1);
    rst_n = 1'b0;
    tick(2);
    @(negedge clk);
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset data_left", 64'(data_left), 64'd0);
    check("midreset data_right", 64'(data_right), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(4);
    q0 = got_q.size();
    send_bits(32'hDEADBE, 32'hEFCAFE, 32, 24, 1'b0, 11, 64);
    send_frame(32'h13579B, 32'h2468AC, 32, 24, 1'b0);
    send_frame(32'hFEDCBA, 32'h0A0B0C, 32, 24, 1'b0);
    send_frame(32'h777777, 32'h888888, 32, 24, 1'b0);
    tick(8);
    check("post-reset pair count", 64'(got_q.size() - q0), 64'd2);
    if (got_q.size() > q0 + 1) begin
      check("post-reset pair 0", 64'(got_q[q0]), 64'h13579B_2468AC);
      check("post-reset pair 1", 64'(got_q[q0+1]), 64'hFEDCBA_0A0B0C);
    end
    $display("midword reset seq: partial frame discarded");

    // 100 random frames against a scoreboard.
    lj_mode = 1'b0;
    out_ready = 1'b1;
    do_reset();
    q0 = got_q.size();
    o0 = ovr_cnt;
    for (int f = 0; f < 100; f++) begin
      rl = 32'($urandom_range(0, 32'hFFFFFF));
      rr = 32'($urandom_range(0, 32'hFFFFFF));
      if (f >= 1 && f <= 98) exp_q.push_back({rl[DW-1:0], rr[DW-1:0]});
      send_frame(rl, rr, 32, 24, 1'b0);
    end
    tick(8);
    check("random pair count", 64'(got_q.size() - q0), 64'(exp_q.size()));
    check("random overrun pulses", 64'(ovr_cnt - o0), 64'd0);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (q0 + k < got_q.size()) begin
        check($sformatf("random pair %0d", k), 64'(got_q[q0+k]), 64'(exp_q[k]));
        $display("random pair %0d: got %h expected %h", k, got_q[q0+k], exp_q[k]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx_stream.md
I2S_RX_STREAM -- requirements
Module: i2s_rx_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 24: bits kept per channel word (8..32).
REQ-002 Parameter MAX_SLOT, default 32: maximum SCK periods per channel slot; sets bit-counter width to $clog2(MAX_SLOT+1).
REQ-003 clk  input  1  system clock, at least 8x SCK frequency; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 sck  input  1  I2S bit clock, asynchronous to clk.
REQ-006 ws  input  1  word select, asynchronous; 0 = left, 1 = right.
REQ-007 sd  input  1  serial data, MSB first, changes on SCK falling edge.
REQ-008 lj_mode  input  1  0 = Philips I2S (1-bit delay), 1 = left-justified; quasi-static.
REQ-009 out_ready  input  1  downstream accepts the stereo pair.
REQ-010 out_valid  output  1  a stereo pair is held on data_left/data_right.
REQ-011 data_left  output  DATA_WIDTH  left sample, MSB-aligned.
REQ-012 data_right  output  DATA_WIDTH  right sample, MSB-aligned.
REQ-013 overrun  output  1  one-clk pulse: a completed pair was dropped.
REQ-014 short_word  output  1  one-clk pulse: a channel closed with fewer than DATA_WIDTH bits.

Function
REQ-015 sck, ws and sd SHALL each pass through a 2-flop synchroniser; a registered edge detector SHALL yield one sck_rise strobe per SCK rising edge.
REQ-016 On sck_rise, ws and sd SHALL be sampled together; ws_prev SHALL hold ws from the previous sck_rise.
REQ-017 Bit channel: lj_mode=0 -> ws_prev; lj_mode=1 -> current ws.
REQ-018 A word boundary SHALL occur on the sck_rise where the bit channel differs from the previous bit's channel; the previous channel's word SHALL be closed before the new bit is shifted in.
REQ-019 The first DATA_WIDTH bits of a channel SHALL be shifted in MSB-first; later bits up to MAX_SLOT SHALL be ignored; the bit counter SHALL saturate at MAX_SLOT.
REQ-020 A word closed with n < DATA_WIDTH bits SHALL be left-shifted by DATA_WIDTH-n (zero-filled LSBs), and short_word SHALL pulse.
REQ-021 A closed left word SHALL go to a left holding register; a closed right word SHALL complete the pair.
REQ-022 On pair completion with out_valid=0, or out_valid=1 and out_ready=1 in the same cycle, data_left/data_right SHALL update and out_valid SHALL be 1 on the next clk.
REQ-023 On pair completion with out_valid=1 and out_ready=0, outputs SHALL hold, the pair SHALL be dropped and overrun SHALL pulse.
REQ-024 out_valid SHALL clear the cycle after out_valid&&out_ready, unless REQ-022 reloads it.
REQ-025 Latency: out_valid SHALL rise at most 5 clk after the SCK rising edge that closes the right word.
REQ-026 FSM states: SYNC (after reset: discard bits until the first right->left boundary), LEFT, RIGHT. SYNC->LEFT on that boundary; LEFT<->RIGHT on each boundary. A right close without a preceding left close SHALL drop silently.
REQ-027 A lj_mode change SHALL take effect at the next boundary only.

Reset
REQ-028 With rst_n low: out_valid=0, data_left=0, data_right=0, overrun=0, short_word=0, synchronisers=0, bit counter=0, FSM=SYNC; rst_n may assert mid-word and SHALL discard partial data.
REQ-029 Reset deassertion SHALL be synchronised to clk; it SHALL take effect at the next clk edge.

Structure
REQ-030 Package i2s_pkg SHALL hold the FSM state enum, the MODE_I2S/MODE_LJ constants and the default DATA_WIDTH/MAX_SLOT values.
REQ-031 Sub-module i2s_sync_edge (2-flop synchroniser plus rise/fall strobe) SHALL be instantiated once per asynchronous input.

Verification
REQ-032 I2S, DATA_WIDTH=24, 32-bit slots, L=0xA5A5A5, R=0x3C3C3C, out_ready=1 -> out_valid pulse, data_left=0xA5A5A5, data_right=0x3C3C3C.
REQ-033 LJ mode, same words with no 1-bit delay -> identical outputs; the same stream sent with lj_mode=0 -> mismatch detected.
REQ-034 16-bit slots, DATA_WIDTH=24, L=0xBEEF -> data_left=0xBEEF00, short_word pulses twice per frame.
REQ-035 out_ready=0 for two frames -> the first pair is held, one overrun pulse, the second pair is absent.
REQ-036 rst_n low mid-left-word, then release -> outputs zero, the first partial frame is discarded, the next full frame is correct.
REQ-037 100 random frames with clk:SCK = 8:1, scoreboard comparison -> zero mismatches.
